// File: rtl/escalonador_programas_pkg.sv
// escalonador_pkg: shared states, defaults and next-active-slot selection for the program scheduler
package escalonador_pkg;
  typedef enum logic [2:0] {RUN, SAVE, FINISH, SELECT, LOAD, WAIT, RESTORE} estado_t;
  localparam int PROG_STRIDE_PADRAO = 200;
  // Scans downward so the last hit is the closest slot above atual; slot 0 is always eligible.
  function automatic int proximo_ativo(input logic [31:0] mask, input int atual, input int n);
    int idx;
    proximo_ativo = 0;
    for (int i = n; i >= 1; i--) begin
      idx = (atual + i) % n;
      if (idx == 0 || mask[idx]) proximo_ativo = idx;
    end
  endfunction
endpackage

// File: rtl/escalonador_programas_contador_quantum.sv
// contador_quantum: quantum cycle counter with clear, enable and terminal-count flag
module contador_quantum #(
  parameter int QUANTUM = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(QUANTUM);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  assign tc = en && cnt == CW'(QUANTUM - 1);
endmodule

// File: rtl/escalonador_programas.sv
// escalonador_programas: round-robin program scheduler driving the data-memory context-switch handshake
module escalonador_programas
  import escalonador_pkg::*;
#(
  parameter int NUM_PROG    = 4,
  parameter int QUANTUM     = 64,
  parameter int PROG_STRIDE = PROG_STRIDE_PADRAO,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       pc_atual,
  input  logic                        fim_programa,
  input  logic                        ativar,
  input  logic [$clog2(NUM_PROG)-1:0] ativar_id,
  input  logic [DATA_WIDTH-1:0]       mem_q,
  output logic [$clog2(NUM_PROG)-1:0] programa,
  output logic                        spc,
  output logic [DATA_WIDTH-1:0]       enderecoSpc,
  output logic                        lpc,
  output logic                        endProgram,
  output logic                        pc_stall,
  output logic                        pc_load_valid,
  output logic [DATA_WIDTH-1:0]       pc_load_value,
  output logic [NUM_PROG-1:0]         ativos
);
  localparam int PW = $clog2(NUM_PROG);
  estado_t estado, prox;
  logic tc;
  logic [DATA_WIDTH-1:0] base;
  logic [PW-1:0] prox_prog;
  logic [NUM_PROG-1:0] limpa, seta;

  contador_quantum #(.QUANTUM(QUANTUM)) u_contador (
    .clock(clock),
    .reset_n(reset_n),
    .clr(estado == SELECT),
    .en(enable && estado == RUN),
    .tc(tc)
  );

  assign base      = DATA_WIDTH'(programa) * DATA_WIDTH'(PROG_STRIDE);
  assign prox_prog = PW'(proximo_ativo(32'(ativos), int'(programa), NUM_PROG));

  always_comb begin
    prox = estado;
    unique case (estado)
      RUN:            prox = (fim_programa && programa != '0) ? FINISH : tc ? SAVE : RUN;
      SAVE, FINISH:   prox = SELECT;
      SELECT:         prox = LOAD;
      LOAD:           prox = WAIT;
      WAIT:           prox = RESTORE;
      RESTORE:        prox = RUN;
      default:        prox = RUN;
    endcase
  end

  // An activation landing on the bit FINISH clears is applied after the clear, so it wins.
  always_comb begin
    limpa = '0;
    seta  = '0;
    if (estado == FINISH) limpa[programa] = 1'b1;
    if (ativar) seta[ativar_id] = 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado        <= RUN;
      programa      <= '0;
      ativos        <= NUM_PROG'(1);
      spc           <= 1'b0;
      lpc           <= 1'b0;
      endProgram    <= 1'b0;
      pc_stall      <= 1'b0;
      pc_load_valid <= 1'b0;
      enderecoSpc   <= '0;
      pc_load_value <= '0;
    end else begin
      estado        <= prox;
      spc           <= prox == SAVE;
      lpc           <= prox == LOAD;
      endProgram    <= prox == FINISH;
      pc_stall      <= prox != RUN;
      pc_load_valid <= prox == RESTORE;
      if (prox == SAVE) enderecoSpc <= pc_atual + base;
      if (prox == RESTORE) pc_load_value <= mem_q;
      if (estado == SELECT) programa <= prox_prog;
      ativos <= (ativos & ~limpa) | seta | NUM_PROG'(1);
    end
endmodule

// File: tb/tb_escalonador_programas.sv
// tb_escalonador_programas: directed checks of preemption, program end, activation and reset abort
module tb_escalonador_programas;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] pc_atual = '0;
  logic        fim_programa = 1'b0;
  logic        ativar = 1'b0;
  logic [1:0]  ativar_id = '0;
  logic [31:0] mem_q = '0;
  logic [1:0]  programa;
  logic        spc, lpc, endProgram, pc_stall, pc_load_valid;
  logic [31:0] enderecoSpc, pc_load_value;
  logic [3:0]  ativos;
  int total = 0;
  int bad = 0;
  logic seen_valid;

  escalonador_programas dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .pc_atual(pc_atual),
    .fim_programa(fim_programa),
    .ativar(ativar),
    .ativar_id(ativar_id),
    .mem_q(mem_q),
    .programa(programa),
    .spc(spc),
    .enderecoSpc(enderecoSpc),
    .lpc(lpc),
    .endProgram(endProgram),
    .pc_stall(pc_stall),
    .pc_load_valid(pc_load_valid),
    .pc_load_value(pc_load_value),
    .ativos(ativos)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs pre RUN cycles, then walks the whole SAVE..RESTORE sequence.
  task automatic preempt(input int pre, input logic [31:0] addr, input logic [31:0] prog,
                         input logic [31:0] val);
    repeat (pre) tick;
    chk("pre_spc", spc, 0);
    chk("pre_stall", pc_stall, 0);
    tick;
    chk("save_spc", spc, 1);
    chk("save_addr", enderecoSpc, addr);
    chk("save_stall", pc_stall, 1);
    tick;
    chk("select_spc", spc, 0);
    chk("select_lpc", lpc, 0);
    tick;
    chk("load_lpc", lpc, 1);
    chk("load_prog", programa, prog);
    mem_q = val;
    tick;
    chk("wait_lpc", lpc, 0);
    chk("wait_valid", pc_load_valid, 0);
    tick;
    chk("restore_valid", pc_load_valid, 1);
    chk("restore_value", pc_load_value, val);
    chk("restore_stall", pc_stall, 1);
    tick;
    chk("run_stall", pc_stall, 0);
    chk("run_valid", pc_load_valid, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_prog", programa, 0);
    chk("rst_ativos", ativos, 4'b0001);
    chk("rst_spc", spc, 0);
    chk("rst_stall", pc_stall, 0);
    chk("rst_valid", pc_load_valid, 0);
    chk("rst_addr", enderecoSpc, 0);
    chk("rst_value", pc_load_value, 0);
    tick;
    tick;
    enable = 1'b1;
    pc_atual = 10;
    reset_n = 1'b1;
    // OS alone: reselects itself after 64 cycles
    preempt(63, 10, 0, 10);
    // enable low freezes the quantum
    enable = 1'b0;
    repeat (20) tick;
    chk("hold_spc", spc, 0);
    chk("hold_stall", pc_stall, 0);
    enable = 1'b1;
    // end instruction from the OS is ignored
    fim_programa = 1'b1;
    tick;
    fim_programa = 1'b0;
    chk("os_fim_end", endProgram, 0);
    chk("os_fim_stall", pc_stall, 0);
    ativar = 1'b1;
    ativar_id = 2;
    tick;
    ativar = 1'b0;
    chk("act2_ativos", ativos, 4'b0101);
    pc_atual = 5;
    preempt(61, 5, 2, 0);
    // program 2 finishes: no save, slot cleared, back to OS
    fim_programa = 1'b1;
    tick;
    fim_programa = 1'b0;
    chk("fin_end", endProgram, 1);
    chk("fin_spc", spc, 0);
    chk("fin_stall", pc_stall, 1);
    tick;
    chk("fin_end_off", endProgram, 0);
    chk("fin_ativos", ativos, 4'b0001);
    tick;
    chk("fin_prog", programa, 0);
    chk("fin_lpc", lpc, 1);
    repeat (3) tick;
    chk("fin_run", pc_stall, 0);
    // ativos 1011: 0 -> 1 -> 3 -> 0 -> 1
    ativar = 1'b1;
    ativar_id = 1;
    tick;
    ativar_id = 3;
    tick;
    ativar = 1'b0;
    chk("act13_ativos", ativos, 4'b1011);
    pc_atual = 7;
    preempt(61, 7, 1, 11);
    preempt(63, 207, 3, 12);
    preempt(63, 607, 0, 13);
    preempt(63, 7, 1, 14);
    ativar = 1'b1;
    ativar_id = 2;
    tick;
    ativar = 1'b0;
    preempt(62, 207, 2, 15);
    // activation of slot 2 in the same cycle FINISH clears it
    fim_programa = 1'b1;
    tick;
    fim_programa = 1'b0;
    chk("race_end", endProgram, 1);
    ativar = 1'b1;
    ativar_id = 2;
    tick;
    ativar = 1'b0;
    chk("race_ativos", ativos, 4'b1111);
    tick;
    chk("race_prog", programa, 3);
    repeat (3) tick;
    chk("race_run", pc_stall, 0);
    preempt(63, 607, 0, 16);
    // reset during WAIT aborts the switch
    repeat (63) tick;
    repeat (3) tick;
    chk("abort_load_prog", programa, 1);
    tick;
    chk("abort_wait_stall", pc_stall, 1);
    mem_q = 99;
    reset_n = 1'b0;
    #1;
    chk("abort_stall", pc_stall, 0);
    chk("abort_prog", programa, 0);
    chk("abort_ativos", ativos, 4'b0001);
    chk("abort_addr", enderecoSpc, 0);
    seen_valid = 1'b0;
    repeat (3) begin
      tick;
      seen_valid |= pc_load_valid;
    end
    reset_n = 1'b1;
    repeat (6) begin
      tick;
      seen_valid |= pc_load_valid;
    end
    chk("abort_no_valid", seen_valid, 0);
    chk("abort_value", pc_load_value, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
